// File: rtl/add_seq64_pkg.sv
// add_seq64_pkg: shared definitions for the sequential 64-bit adder.
//   - FSM state encoding (IDLE/RUN/DONE)
//   - default total width and CLA slice width
//   - helpers deriving the slice count and the slice-index width
package add_seq64_pkg;

  localparam int DEF_W_TOTAL = 64;
  localparam int DEF_SLICE_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int nslice(input int w_total, input int slice_w);
    return w_total / slice_w;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice16.sv
// cla_slice16: purely combinational 16-bit carry-lookahead adder slice.
// Four 4-bit groups produce group generate/propagate; a second-level
// lookahead derives the group carries directly from cin.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry into bit 0
//   s     out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15
module cla_slice16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int L = 4 * k;
    assign gg[k] = g[L+3]
                 | (p[L+3] & g[L+2])
                 | (p[L+3] & p[L+2] & g[L+1])
                 | (p[L+3] & p[L+2] & p[L+1] & g[L]);
    assign gp[k] = &p[L +: 4];

    // Bit carries inside the group, looked ahead from the group carry-in.
    assign c[L]   = gc[k];
    assign c[L+1] = g[L] | (p[L] & gc[k]);
    assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & gc[k]);
    assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                  | (p[L+2] & p[L+1] & p[L] & gc[k]);
  end

  // Second-level lookahead across the four groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign s    = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/add_seq64.sv
// add_seq64: multi-cycle wide adder reusing one 16-bit CLA slice, one slice
// per clock from LSB to MSB, with a registered inter-slice carry.
// Ports:
//   Clk        in   1        clock, rising edge
//   Rst_n      in   1        asynchronous active-low reset
//   In_valid   in   1        operand pair present
//   In_ready   out  1        accepting operands (IDLE only)
//   A, B       in   W_TOTAL  operands
//   Cin        in   1        carry into bit 0
//   Out_valid  out  1        Sum/Cout/Ovf hold a completed result
//   Out_ready  in   1        consumer takes the result
//   Sum        out  W_TOTAL  A+B+Cin modulo 2^W_TOTAL
//   Cout       out  1        carry out of the MSB
//   Ovf        out  1        two's-complement overflow
module add_seq64
  import add_seq64_pkg::*;
#(
  parameter int W_TOTAL = DEF_W_TOTAL,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [W_TOTAL-1:0] A,
  input  logic [W_TOTAL-1:0] B,
  input  logic               Cin,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [W_TOTAL-1:0] Sum,
  output logic               Cout,
  output logic               Ovf
);

  localparam int NSLICE = nslice(W_TOTAL, SLICE_W);
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  logic [1:0]         state;
  logic [IDX_W-1:0]   idx;
  logic               carry_r;
  logic [W_TOTAL-1:0] a_r;
  logic [W_TOTAL-1:0] b_r;
  logic [W_TOTAL-1:0] sum_r;
  logic               cout_r;
  logic               ovf_r;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;
  logic               ovf_next;

  assign slice_a = a_r[idx*SLICE_W +: SLICE_W];
  assign slice_b = b_r[idx*SLICE_W +: SLICE_W];

  cla_slice16 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_r),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Signed overflow: like-signed operands whose sum flips sign. The new MSB
  // of the sum comes straight from the slice on the final processing edge.
  assign ovf_next = (a_r[W_TOTAL-1] == b_r[W_TOTAL-1]) &&
                    (slice_s[SLICE_W-1] != a_r[W_TOTAL-1]);

  // Operand capture: data only, no reset needed.
  always_ff @(posedge Clk) begin
    if (state == ST_IDLE && In_valid) begin
      a_r <= A;
      b_r <= B;
    end
  end

  // Control, slice walk and result registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (In_valid) begin
            idx     <= '0;
            carry_r <= Cin;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r[idx*SLICE_W +: SLICE_W] <= slice_s;
          carry_r                       <= slice_cout;
          if (idx == LAST_IDX) begin
            // idx stays on the last slice so it never wraps.
            cout_r <= slice_cout;
            ovf_r  <= ovf_next;
            state  <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (Out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign In_ready  = (state == ST_IDLE);
  assign Out_valid = (state == ST_DONE);
  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;

endmodule

// File: tb/tb_add_seq64.sv
// tb_add_seq64: self-checking bench for add_seq64 using a directed vector
// table, hand-written multi-cycle sequences and a back-to-back random run.
module tb_add_seq64;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        In_valid = 1'b0;
  logic        In_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        Cin = 1'b0;
  logic        Out_valid;
  logic        Out_ready = 1'b0;
  logic [63:0] Sum;
  logic        Cout;
  logic        Ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  add_seq64 dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present operands, wait (bounded) for In_ready, let one edge accept them.
  // Returns #1 after the acceptance edge with In_valid dropped.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic c);
    int g;
    A = a; B = b; Cin = c; In_valid = 1'b1;
    g = 0;
    while (!In_ready && g < 50) begin
      @(posedge Clk); #1; g++;
    end
    chk("accept_ready", 64'(In_ready), 64'd1);
    @(posedge Clk); #1;
    In_valid = 1'b0;
  endtask

  // Count edges until Out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!Out_valid && lat < 20) begin
      @(posedge Clk); #1; lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int prev;
    int g;
    logic [63:0] ra, rb;
    logic        rc;
    logic [64:0] tot;
    logic        eo;

    vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[3]  = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[4]  = '{64'h1, 64'h2, 1'b1, 64'h4, 1'b0, 1'b0};
    vecs[5]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[6]  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};
    vecs[8]  = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[9]  = '{64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 64'h0000_0001_0000_0000, 1'b1, 1'b0};
    vecs[10] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};

    // Reset state
    #1;
    chk("rst_in_ready", 64'(In_ready), 64'd1);
    chk("rst_out_valid", 64'(Out_valid), 64'd0);
    chk("rst_sum", Sum, 64'd0);
    chk("rst_cout", 64'(Cout), 64'd0);
    chk("rst_ovf", 64'(Ovf), 64'd0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_sum", i), Sum, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), 64'(Cout), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 64'(Ovf), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_in_ready_busy", i), 64'(In_ready), 64'd0);
      Out_ready = 1'b1;
      @(posedge Clk); #1;
      Out_ready = 1'b0;
      chk($sformatf("vec%0d_in_ready_back", i), 64'(In_ready), 64'd1);
      chk($sformatf("vec%0d_sum_retained", i), Sum, vecs[i].sum);
    end

    // Input isolation: ports scrambled during RUN, Out_ready high early
    issue(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0);
    Out_ready = 1'b1;
    lat = 0;
    while (!Out_valid && lat < 20) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = ~Cin;
      @(posedge Clk); #1; lat++;
    end
    chk("iso_latency", 64'(lat), 64'd4);
    chk("iso_sum", Sum, 64'h3333_3333_3333_3333);
    chk("iso_flags", {62'd0, Cout, Ovf}, 64'd0);
    @(posedge Clk); #1;
    Out_ready = 1'b0;
    chk("iso_idle", 64'(In_ready), 64'd1);

    // Back-pressure: result must hold for 5 cycles
    issue(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b0);
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      chk("bp_out_valid", 64'(Out_valid), 64'd1);
      chk("bp_sum", Sum, 64'h3);
      chk("bp_flags", {62'd0, Cout, Ovf}, 64'd3);
      chk("bp_in_ready", 64'(In_ready), 64'd0);
    end
    Out_ready = 1'b1;
    @(posedge Clk); #1;
    Out_ready = 1'b0;
    chk("bp_release_valid", 64'(Out_valid), 64'd0);
    chk("bp_release_ready", 64'(In_ready), 64'd1);

    // Reset two cycles after acceptance
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(posedge Clk);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(Out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(In_ready), 64'd1);
    chk("mid_rst_sum", Sum, 64'd0);
    chk("mid_rst_cout", 64'(Cout), 64'd0);
    chk("mid_rst_ovf", 64'(Ovf), 64'd0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;
    issue(vecs[1].a, vecs[1].b, vecs[1].cin);
    wait_out(lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_sum", Sum, vecs[1].sum);
    chk("post_rst_flags", {62'd0, Cout, Ovf}, {62'd0, vecs[1].cout, vecs[1].ovf});
    Out_ready = 1'b1;
    @(posedge Clk); #1;

    // Back-to-back random regression against an arithmetic reference
    In_valid = 1'b1;
    prev = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      A = ra; B = rb; Cin = rc;
      g = 0;
      while (!In_ready && g < 50) begin
        @(posedge Clk); #1; g++;
      end
      @(posedge Clk); #1;
      acc = cyc;
      if (i > 0) chk("rand_interval", 64'(acc - prev), 64'd6);
      prev = acc;
      wait_out(lat);
      tot = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      eo  = (ra[63] == rb[63]) && (tot[63] != ra[63]);
      chk("rand_sum", Sum, tot[63:0]);
      chk("rand_flags", {62'd0, Cout, Ovf}, {62'd0, tot[64], eo});
      @(posedge Clk); #1;
    end
    In_valid = 1'b0;
    Out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
